// File: rtl/max_seq_pkg.sv
// Shared definitions for the burst-maximum sequencing controller.
//   state_t    : controller state encoding (IDLE / ACCUM / DONE)
//   WIDTH_DEF  : default data word width
//   CNT_W_DEF  : default width of the burst length and index counters
package max_seq_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/max_cmp.sv
// Combinational greater-of-two comparator shared by the controller.
// Ports:
//   a, b  : unsigned operands [WIDTH]
//   gt    : a > b (strict, unsigned)
//   max   : gt ? a : b  (ties select b)
module max_cmp
  import max_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic [WIDTH-1:0] max
);

  assign gt  = (a > b);
  assign max = gt ? a : b;

endmodule

// File: rtl/max_seq_ctrl.sv
// Streams a burst of unsigned words through one shared comparator and
// reports the burst maximum plus the index of its first occurrence.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, len          : begin a transaction of len words (sampled in IDLE)
//   in_valid/in_ready   : producer handshake, in_data is the word
//   out_valid/out_ready : consumer handshake for out_max / out_idx
//   busy                : high while a transaction is in ACCUM or DONE
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] cur_max_q;
  logic [CNT_W-1:0] cur_idx_q;

  logic             hs;
  logic             last_word;
  logic             cmp_gt;
  logic [WIDTH-1:0] cmp_max;

  max_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a   (in_data),
    .b   (cur_max_q),
    .gt  (cmp_gt),
    .max (cmp_max)
  );

  assign hs        = in_valid & in_ready;
  // Terminal check is made on the pre-increment count, so cnt never wraps
  // even for the longest burst.
  assign last_word = (cnt_q == len_q - CNT_W'(1));

  // State register.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)           state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (hs && last_word) state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Output decode (Moore: depends on state only).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters and running-max registers. The running max doubles as the
  // result register: it is frozen outside ACCUM, so it is stable in DONE
  // and keeps its last value in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      cur_max_q <= '0;
      cur_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt_q <= '0;
            if (len == '0) begin
              cur_max_q <= '0;
              cur_idx_q <= '0;
            end
          end
        end
        ACCUM: begin
          if (hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == '0) begin
              // First word seeds the max regardless of the stale register.
              cur_max_q <= in_data;
              cur_idx_q <= '0;
            end else if (cmp_gt) begin
              // Strict compare: ties keep the earlier index.
              cur_max_q <= cmp_max;
              cur_idx_q <= cnt_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_max = cur_max_q;
  assign out_idx = cur_idx_q;

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Self-checking bench for max_seq_ctrl: directed scenarios plus randomized
// bursts, each compared against a plain maximum/first-index model.
module tb_max_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_idx;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] words[$];

  max_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete transaction over the contents of 'words'.
  //   gap  : idle cycles before each word (negative -> random 0..-gap)
  //   bp   : cycles out_ready is held low once the result is valid
  //   poke : hold start high (with a different len) throughout ACCUM
  task automatic burst(input string tag, input int gap, input int bp, input bit poke);
    int               n;
    int               g;
    logic [WIDTH-1:0] exp_max;
    int               exp_idx;

    n = words.size();
    exp_max = '0;
    exp_idx = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || words[i] > exp_max) begin
        exp_max = words[i];
        exp_idx = i;
      end
    end

    check({tag, "/idle_busy"}, busy, 0);
    check({tag, "/idle_in_ready"}, in_ready, 0);

    start = 1'b1;
    len   = CNT_W'(n);
    step();
    start = poke;
    len   = CNT_W'(1);

    if (n > 0) begin
      check({tag, "/accum_busy"}, busy, 1);
      check({tag, "/accum_in_ready"}, in_ready, 1);
    end

    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? $urandom_range(-gap, 0) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        step();
        check({tag, "/bubble_in_ready"}, in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      step();
      in_valid = 1'b0;
      if (i != n - 1) check({tag, "/mid_out_valid"}, out_valid, 0);
    end
    start = 1'b0;

    // Result must be valid exactly one cycle after the last handshake.
    check({tag, "/out_valid"}, out_valid, 1);
    check({tag, "/done_in_ready"}, in_ready, 0);
    check({tag, "/done_busy"}, busy, 1);
    check({tag, "/out_max"}, out_max, exp_max);
    check({tag, "/out_idx"}, out_idx, exp_idx);

    repeat (bp) begin
      out_ready = 1'b0;
      step();
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_max"}, out_max, exp_max);
      check({tag, "/hold_idx"}, out_idx, exp_idx);
    end

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "/ret_out_valid"}, out_valid, 0);
    check({tag, "/ret_busy"}, busy, 0);
    check({tag, "/keep_max"}, out_max, exp_max);
    check({tag, "/keep_idx"}, out_idx, exp_idx);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("reset/in_ready", in_ready, 0);
    check("reset/out_valid", out_valid, 0);
    check("reset/busy", busy, 0);
    check("reset/out_max", out_max, 0);
    check("reset/out_idx", out_idx, 0);
    rst = 1'b0;
    step();
    check("idle/hold", busy, 0);

    words = '{16'd10, 16'd20};
    burst("basic", 0, 0, 1'b0);

    words = '{16'd40, 16'd30};
    burst("desc", 0, 0, 1'b0);

    words = '{16'd7, 16'hFFFF, 16'hFFFF, 16'd3};
    burst("ties", 0, 0, 1'b0);

    words = '{16'd5, 16'd9, 16'd2};
    burst("bubbles", 2, 5, 1'b0);

    words = {};
    burst("len0", 0, 2, 1'b0);

    words = '{16'd100, 16'd300, 16'd200, 16'd300};
    burst("start_in_accum", 1, 1, 1'b1);

    // Reset in the middle of a burst discards it.
    start = 1'b1;
    len   = CNT_W'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(50 + i);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst/in_ready", in_ready, 0);
    check("midrst/out_valid", out_valid, 0);
    check("midrst/busy", busy, 0);
    check("midrst/out_max", out_max, 0);
    step();
    check("midrst/idle", busy, 0);

    words = '{16'd12};
    burst("after_rst", 0, 0, 1'b0);

    // Reset while a result is pending.
    words = '{16'd77, 16'd88};
    start = 1'b1;
    len   = CNT_W'(2);
    step();
    start = 1'b0;
    foreach (words[i]) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    in_valid = 1'b0;
    check("donerst/pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("donerst/out_valid", out_valid, 0);
    check("donerst/busy", busy, 0);
    check("donerst/out_max", out_max, 0);
    check("donerst/out_idx", out_idx, 0);

    // Longest burst: counters must not wrap.
    words = {};
    for (int i = 0; i < 255; i++) words.push_back(WIDTH'($urandom_range(2000, 0)));
    burst("max_len", 0, 0, 1'b0);

    // Randomized bursts; a narrow value range in half of them forces ties.
    for (int t = 0; t < 25; t++) begin
      int n;
      int hi;
      n  = $urandom_range(12, 1);
      hi = (t % 2 == 0) ? 5 : 65535;
      words = {};
      for (int i = 0; i < n; i++) words.push_back(WIDTH'($urandom_range(hi, 0)));
      burst($sformatf("rand%0d", t), -2, $urandom_range(3, 0), 1'(t % 3 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
